// File: rtl/dom_gf2_xmulb_xor_sqsc_pkg.sv
// Shared GF(2^2) arithmetic (normal basis {W^2, W}) and share-pair helpers
// for the DOM X*Y ^ SqSc(X^B) gadget.
package dom_gf2_xmulb_xor_sqsc_pkg;

    localparam int GF2_W = 2;

    // bit1 is the coefficient of W, bit0 the coefficient of W^2
    function automatic logic [GF2_W-1:0] gf2_mul(input logic [GF2_W-1:0] a,
                                                 input logic [GF2_W-1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    function automatic logic [GF2_W-1:0] gf2_sqsc(input logic [GF2_W-1:0] a);
        return {a[1] ^ a[0], a[0]};
    endfunction

    // Lexicographic index of the unordered pair {i,j}, i != j
    function automatic int pair_index(input int i, input int j, input int shares);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

endpackage

// File: rtl/dom_gf2_xmulb_xor_sqsc_cross.sv
// One registered DOM cross-domain product a*b ^ z; the register is the glitch
// barrier that must sit before any mixing with other domains.
module dom_cross_term_gf2
    import dom_gf2_xmulb_xor_sqsc_pkg::*;
(
    input  logic             clk,
    input  logic             rstN,
    input  logic [GF2_W-1:0] a,
    input  logic [GF2_W-1:0] b,
    input  logic [GF2_W-1:0] z,
    input  logic [GF2_W-1:0] fold,
    output logic [GF2_W-1:0] q
);

    // fold lets a same-domain term share this register (first-order variant)
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q <= '0;
        end else begin
            q <= gf2_mul(a, b) ^ z ^ fold;
        end
    end

endmodule

// File: rtl/dom_gf2_xmulb_xor_sqsc.sv
// Masked GF(2^2) gadget Q = X*Y ^ SqSc(X^B) with an arbitrary number of
// Boolean shares, DOM-style registered cross terms.
module dom_gf2_xmulb_xor_sqsc
    import dom_gf2_xmulb_xor_sqsc_pkg::*;
#(
    parameter int PIPELINED                = 1,
    parameter int FIRST_ORDER_OPTIMIZATION = 0,
    parameter int SHARES                   = 2
) (
    input  logic                         ClkxCI,
    input  logic                         RstxBI,
    input  logic [GF2_W*SHARES-1:0]      _XxDI,
    input  logic [GF2_W*SHARES-1:0]      _BxDI,
    input  logic [GF2_W*SHARES-1:0]      _YxDI,
    input  logic [SHARES*(SHARES-1)-1:0] _ZxDI,
    output logic [GF2_W*SHARES-1:0]      _QxDO
);

    for (genvar i = 0; i < SHARES; i++) begin : gShare
        logic [GF2_W-1:0] xShare;
        logic [GF2_W-1:0] innerTerm;
        logic [GF2_W-1:0] crossTerm [SHARES];
        logic [GF2_W-1:0] crossSum;

        assign xShare    = _XxDI[GF2_W*i +: GF2_W];
        assign innerTerm = gf2_mul(xShare, _YxDI[GF2_W*i +: GF2_W])
                         ^ gf2_sqsc(xShare ^ _BxDI[GF2_W*i +: GF2_W]);

        for (genvar j = 0; j < SHARES; j++) begin : gCross
            if (j != i) begin : gTerm
                dom_cross_term_gf2 uCross (
                    .clk  (ClkxCI),
                    .rstN (RstxBI),
                    .a    (xShare),
                    .b    (_YxDI[GF2_W*j +: GF2_W]),
                    .z    (_ZxDI[GF2_W*pair_index(i, j, SHARES) +: GF2_W]),
                    .fold ((FIRST_ORDER_OPTIMIZATION != 0) ? innerTerm : '0),
                    .q    (crossTerm[j])
                );
            end else begin : gDiag
                assign crossTerm[j] = '0;
            end
        end

        always_comb begin
            crossSum = '0;
            for (int k = 0; k < SHARES; k++) begin
                crossSum = crossSum ^ crossTerm[k];
            end
        end

        // With SHARES=2 folding, the inner term already lives in the cross register
        if (FIRST_ORDER_OPTIMIZATION != 0) begin : gFolded
            assign _QxDO[GF2_W*i +: GF2_W] = crossSum;
        end else if (PIPELINED != 0) begin : gPiped
            logic [GF2_W-1:0] innerReg;

            always_ff @(posedge ClkxCI or negedge RstxBI) begin
                if (!RstxBI) begin
                    innerReg <= '0;
                end else begin
                    innerReg <= innerTerm;
                end
            end

            assign _QxDO[GF2_W*i +: GF2_W] = crossSum ^ innerReg;
        end else begin : gComb
            assign _QxDO[GF2_W*i +: GF2_W] = crossSum ^ innerTerm;
        end
    end

endmodule

// File: tb/tb_dom_gf2_xmulb_xor_sqsc.sv
// Randomized self-checking bench for dom_gf2_xmulb_xor_sqsc in four configurations
// against a polynomial-basis GF(2^2) reference model.
module tb_dom_gf2_xmulb_xor_sqsc;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic [3:0] x2 = '0, b2 = '0, y2 = '0;
    logic [1:0] z2 = '0;
    logic [5:0] x3 = '0, b3 = '0, y3 = '0, z3 = '0;
    logic [3:0] qPipe, qComb, qFold;
    logic [5:0] qWide;
    int         errorCount = 0;
    int         checkCount = 0;

    always #5 clk = ~clk;

    dom_gf2_xmulb_xor_sqsc #(.PIPELINED(1), .FIRST_ORDER_OPTIMIZATION(0), .SHARES(2)) dutPipe (
        .ClkxCI(clk), .RstxBI(rstN), ._XxDI(x2), ._BxDI(b2), ._YxDI(y2), ._ZxDI(z2), ._QxDO(qPipe));
    dom_gf2_xmulb_xor_sqsc #(.PIPELINED(0), .FIRST_ORDER_OPTIMIZATION(0), .SHARES(2)) dutComb (
        .ClkxCI(clk), .RstxBI(rstN), ._XxDI(x2), ._BxDI(b2), ._YxDI(y2), ._ZxDI(z2), ._QxDO(qComb));
    dom_gf2_xmulb_xor_sqsc #(.PIPELINED(1), .FIRST_ORDER_OPTIMIZATION(1), .SHARES(2)) dutFold (
        .ClkxCI(clk), .RstxBI(rstN), ._XxDI(x2), ._BxDI(b2), ._YxDI(y2), ._ZxDI(z2), ._QxDO(qFold));
    dom_gf2_xmulb_xor_sqsc #(.PIPELINED(1), .FIRST_ORDER_OPTIMIZATION(0), .SHARES(3)) dutWide (
        .ClkxCI(clk), .RstxBI(rstN), ._XxDI(x3), ._BxDI(b3), ._YxDI(y3), ._ZxDI(z3), ._QxDO(qWide));

    // Convert to polynomial basis {W,1} (W^2 = W+1), multiply mod W^2+W+1, convert back
    function automatic logic [1:0] refMul(input logic [1:0] a, input logic [1:0] b);
        logic p1, p0, r1, r0, c1, c0;
        p1 = a[1] ^ a[0];
        p0 = a[0];
        r1 = b[1] ^ b[0];
        r0 = b[0];
        c1 = (p1 & r1) ^ (p1 & r0) ^ (p0 & r1);
        c0 = (p1 & r1) ^ (p0 & r0);
        return {c1 ^ c0, c0};
    endfunction

    function automatic logic [1:0] refQ(input logic [1:0] x, input logic [1:0] y, input logic [1:0] b);
        return refMul(x, y) ^ refMul(refMul(x ^ b, x ^ b), 2'b01);
    endfunction

    function automatic logic [1:0] fold2(input logic [3:0] v);
        return v[3:2] ^ v[1:0];
    endfunction

    function automatic logic [1:0] fold3(input logic [5:0] v);
        return v[5:4] ^ v[3:2] ^ v[1:0];
    endfunction

    function automatic logic [1:0] rnd2();
        logic [31:0] r;
        r = $urandom;
        return r[1:0];
    endfunction

    function automatic logic [5:0] rnd6();
        logic [31:0] r;
        r = $urandom;
        return r[5:0];
    endfunction

    // Expected individual shares for 3 shares; pair randomness enumerated lexicographically
    function automatic logic [5:0] refShares3(input logic [5:0] x, input logic [5:0] y,
                                              input logic [5:0] b, input logic [5:0] z);
        logic [1:0] zp [3][3];
        logic [1:0] qi;
        logic [5:0] q;
        int p;
        p = 0;
        for (int i = 0; i < 3; i++) begin
            zp[i][i] = '0;
            for (int j = i + 1; j < 3; j++) begin
                zp[i][j] = z[2*p +: 2];
                zp[j][i] = z[2*p +: 2];
                p++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            qi = refQ(x[2*i +: 2], y[2*i +: 2], b[2*i +: 2]);
            for (int j = 0; j < 3; j++) begin
                if (j != i) qi = qi ^ refMul(x[2*i +: 2], y[2*j +: 2]) ^ zp[i][j];
            end
            q[2*i +: 2] = qi;
        end
        return q;
    endfunction

    function automatic logic [3:0] refShares2(input logic [3:0] x, input logic [3:0] y,
                                              input logic [3:0] b, input logic [1:0] z);
        logic [1:0] q0, q1;
        q0 = refQ(x[1:0], y[1:0], b[1:0]) ^ refMul(x[1:0], y[3:2]) ^ z;
        q1 = refQ(x[3:2], y[3:2], b[3:2]) ^ refMul(x[3:2], y[1:0]) ^ z;
        return {q1, q0};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] expected);
        checkCount++;
        if (got !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] x, input logic [1:0] y, input logic [1:0] b);
        logic [1:0] sx, sy, sb;
        sx = rnd2();
        sy = rnd2();
        sb = rnd2();
        x2 = {x ^ sx, sx};
        y2 = {y ^ sy, sy};
        b2 = {b ^ sb, sb};
        z2 = rnd2();
        x3 = rnd6();
        y3 = rnd6();
        b3 = rnd6();
        z3 = rnd6();
    endtask

    logic [1:0] knownX [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    logic [1:0] knownB [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
    logic [1:0] knownQ [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};

    initial begin
        logic [7:0] n8;
        logic [1:0] fx, fy, fb;

        // Reset with random inputs: registered outputs clear, comb inner term passes
        #2 rstN = 1'b0;
        applyStimulus(rnd2(), rnd2(), rnd2());
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetPipe", 8'(qPipe), 8'h00);
        checkOutput("resetFold", 8'(qFold), 8'h00);
        checkOutput("resetWide", 8'(qWide), 8'h00);
        checkOutput("resetComb", 8'(qComb),
                    8'({refQ(x2[3:2], y2[3:2], b2[3:2]), refQ(x2[1:0], y2[1:0], b2[1:0])}));

        rstN = 1'b1;
        applyStimulus(2'b11, 2'b11, 2'b11);
        @(posedge clk);
        #1;
        checkOutput("releasePipe", 8'(fold2(qPipe)), 8'(2'b11));
        checkOutput("releaseWide", 8'(qWide), 8'(refShares3(x3, y3, b3, z3)));

        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b00, 2'b00, 2'b00);
            @(posedge clk);
            #1;
            checkOutput("zeroPipe", 8'(fold2(qPipe)), 8'h00);
            checkOutput("zeroComb", 8'(fold2(qComb)), 8'h00);
        end

        for (int k = 0; k < 5; k++) begin
            applyStimulus(knownX[k], knownB[k], knownB[k]);
            @(posedge clk);
            #1;
            checkOutput("knownPipe", 8'(fold2(qPipe)), 8'(knownQ[k]));
            checkOutput("knownFold", 8'(fold2(qFold)), 8'(knownQ[k]));
            checkOutput("knownComb", 8'(fold2(qComb)), 8'(knownQ[k]));
        end

        // Z sweep: unmasked result fixed, share 0 tracks Z
        applyStimulus(rnd2(), rnd2(), rnd2());
        for (int k = 0; k < 4; k++) begin
            z2 = 2'(k);
            @(posedge clk);
            #1;
            checkOutput("zSweepUnmasked", 8'(fold2(qPipe)), 8'(refQ(fold2(x2), fold2(y2), fold2(b2))));
            checkOutput("zSweepShares", 8'(qPipe), 8'(refShares2(x2, y2, b2, z2)));
        end

        // Full-throughput exhaustive sweep, Y tied to B
        for (int n = 0; n < 256; n++) begin
            n8 = 8'(n);
            x2 = n8[3:0];
            b2 = n8[7:4];
            y2 = b2;
            z2 = rnd2();
            x3 = rnd6();
            b3 = rnd6();
            y3 = rnd6();
            z3 = rnd6();
            @(posedge clk);
            #1;
            checkOutput("sweepPipe", 8'(fold2(qPipe)), 8'(refQ(fold2(x2), fold2(y2), fold2(b2))));
            checkOutput("sweepFold", 8'(fold2(qFold)), 8'(refQ(fold2(x2), fold2(y2), fold2(b2))));
            checkOutput("sweepWide", 8'(fold3(qWide)), 8'(refQ(fold3(x3), fold3(y3), fold3(b3))));
            checkOutput("sweepWideShares", 8'(qWide), 8'(refShares3(x3, y3, b3, z3)));
        end

        // Exhaustive sweep with inputs held two edges for the combinational variant
        for (int n = 0; n < 256; n++) begin
            n8 = 8'(n);
            x2 = n8[3:0];
            b2 = n8[7:4];
            y2 = b2;
            z2 = rnd2();
            @(posedge clk);
            #1;
            z2 = rnd2();
            @(posedge clk);
            #1;
            fx = fold2(x2);
            fy = fold2(y2);
            fb = fold2(b2);
            checkOutput("heldComb", 8'(fold2(qComb)), 8'(refQ(fx, fy, fb)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dom_gf2_xmulb_xor_sqsc.md
Name: dom_gf2_xmulb_xor_sqsc

Overview:
- Masked (Domain-Oriented Masking, DOM) GF(2^2) gadget, normal basis {W^2, W}, arbitrary share count.
- Computes Q = (X ⊗ Y) ⊕ SqSc(X ⊕ B) on Boolean shares, with fresh randomness Z for the cross-domain products.
- Used inside the masked GF(2^4) inverter of the DOM AES S-box. Callers normally tie Y to B, giving Q = X·B ⊕ SqSc(X ⊕ B).

Parameters:
- PIPELINED, 1: 1 = every term registered, so output depends only on registers. 0 = inner-domain and linear terms combinational; only cross-domain terms registered.
- FIRST_ORDER_OPTIMIZATION, 0: 1 (legal only with SHARES=2) = inner and linear terms are folded into the same per-share register as that share's cross term. Function and latency are unchanged.
- SHARES, 2: number of Boolean shares, ≥2.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  asynchronous, active-low reset.
- _XxDI  in  2*SHARES  shares of X; share i is bits [2i+1:2i].
- _BxDI  in  2*SHARES  shares of B (linear operand), same packing.
- _YxDI  in  2*SHARES  shares of Y (multiplier operand), same packing.
- _ZxDI  in  SHARES*(SHARES-1)  fresh randomness. One 2-bit value Z_p per share pair p=(i,j), i<j. Pairs are enumerated lexicographically; p occupies bits [2p+1:2p].
- _QxDO  out  2*SHARES  shares of Q, same packing.

Behaviour:
- Element packing: bit1 = coefficient of W, bit0 = coefficient of W^2.
- GF(2^2) multiply a⊗b:
  - e = (a1^a0)&(b1^b0)
  - result = {(a1&b1)^e, (a0&b0)^e}
- SqSc(a) (square, then scale by W^2) = {a1^a0, a0}.
- Share i output:
  - Q_i = X_i⊗Y_i ⊕ SqSc(X_i⊕B_i) ⊕ Σ_{j≠i} REG(X_i⊗Y_j ⊕ Z_{pair(i,j)})
  - Both members of a pair use the same Z.
- Cross-domain terms must always be registered before any XOR with other domains. This is a glitch barrier and is mandatory in every configuration.
- PIPELINED=1:
  - Inner term X_i⊗Y_i ⊕ SqSc(X_i⊕B_i) is also registered.
  - _QxDO is a pure XOR of registers.
  - Latency is exactly 1 cycle: inputs sampled at edge k appear on _QxDO after edge k.
  - Full throughput, a new input every cycle.
- PIPELINED=0:
  - Inner term is combinational from current X, Y, B.
  - X, Y, B must be held for the cycle after sampling, i.e. ≥2 edges.
  - Output is valid once the cross registers load.
- Unmasked correctness: XOR over all _QxDO shares = X⊗Y ⊕ SqSc(X⊕B), where X, Y, B are the XOR of their shares. This must hold for every share split and every Z.
- Reset: all registers clear to 0 asynchronously while RstxBI=0, so _QxDO = 0 during reset. In PIPELINED=0 the combinational inner term still passes through during reset. The first valid output comes one edge after RstxBI rises with inputs applied.
- No handshake, no valid signal: the caller tracks latency.
- Randomness Z must be fresh each cycle for security. Functional results are independent of Z.

Decomposition:
- Shared package:
  - functions gf2_mul(a,b) and gf2_sqsc(a)
  - localparam GF2_W = 2
  - function pair_index(i,j, SHARES) for Z slicing
- Natural sub-module: dom_cross_term_gf2. It holds one registered cross product X_i⊗Y_j ⊕ Z and has a reset.
- Top level generates SHARES×(SHARES-1) cross-term instances plus SHARES inner-term paths.

Test Plan:
- Reset: hold RstxBI=0 with random inputs -> _QxDO=0 while reset is asserted. Release -> outputs are correct one edge later.
- Zero: X=Y=B=0 in any share split -> unmasked Q=0 after 1 cycle.
- Known values, unmasked, Y=B:
  - X=B=01 -> Q=10
  - X=B=10 -> Q=01
  - X=B=11 -> Q=11
  - X=01, B=10 -> Q=10
  - X=10, B=00 -> Q=10
- Exhaustive SHARES=2, PIPELINED=1: all 256 combinations of (X_0, X_1, B_0, B_1) with Y=B and random Z, one per cycle -> each unmasked Q matches the reference model exactly 1 cycle after input.
- Z independence: fixed X, Y, B with Z swept 0..3 -> unmasked Q unchanged. Individual share values change with Z.
- Configurations: repeat the exhaustive sweep for PIPELINED=0 (inputs held 2 cycles), FIRST_ORDER_OPTIMIZATION=1, and SHARES=3 (random splits) -> all unmasked results correct.
